mem_port_arbiter: RTL

//  Shares one memory port between the fetch stage (IF, read-only) and the memory stage (MEM, load/store).
//  It sequences one outstanding transaction at a time and returns each response to its owner.
//  It drives f_stall/m_stall back to the pipeline control and hazard logic.
//  It sits between the pipeline stages and the unified memory model.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_starve_ctr.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the memory port arbiter.
//   - FSM state encoding (ST_IDLE / ST_ISSUE / ST_WAIT)
//   - transaction owner encoding (OWN_F = fetch, OWN_D = data)
//   - access size encoding (SZ_B / SZ_H / SZ_W)
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: counts consecutive arbitrations that fetch lost to
// data and raises force_fetch once the count reaches LIMIT. Used only when
// the arbiter is built with ARB_FAIRNESS_EN.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous, active-low
//   fetch_lost  in   an arbitration was held and fetch lost to data
//   fetch_won   in   an arbitration was held and fetch won
//   force_fetch out  count == LIMIT: fetch must win the next arbitration
module mem_arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic fetch_lost,
  input  logic fetch_won,
  output logic force_fetch
);

  localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at LIMIT; any fetch win starts the count over.
  always_comb begin
    cnt_d = cnt_q;
    if (fetch_won) begin
      cnt_d = '0;
    end else if (fetch_lost && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_fetch = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF,
// read-only) and the memory stage (MEM, load/store). One transaction is
// outstanding at a time; each response is routed back to its owner.
//
// Build option: ARB_FAIRNESS_EN -- when defined, fetch is forced to win after
// STARVE_LIMIT consecutive losses to data. Undefined: data always wins.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-low reset
//   if_req/if_addr               fetch request (held until if_valid)
//   if_rdata/if_valid            fetch response (if_valid is a 1-cycle pulse)
//   flush                        PC redirect; in-flight fetch response dropped
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_size             data request (held until dm_valid)
//   dm_rdata/dm_valid            load data / store ack (1-cycle pulse)
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_size/mem_gnt   memory request channel
//   mem_rvalid/mem_rdata         memory response channel
//   f_stall/m_stall              combinational stalls to pipeline control
//   dbg_state                    current FSM state (mem_arb_pkg encoding)
//
// Handshakes: a requester raises *_req with its fields and holds both
// unchanged until the matching *_valid pulse; the cycle of the pulse is the
// completion cycle. Toward memory, mem_req and its fields stay stable until
// the cycle mem_gnt is seen high; the response arrives as a single mem_rvalid
// cycle, no earlier than the cycle after mem_gnt.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              flush,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [1:0]        dm_size,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              f_stall,
  output logic              m_stall,
  output logic [1:0]        dbg_state
);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              drop_q, drop_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;

  logic f_cand, d_cand, arb_go, pick_f, resp;

`ifdef ARB_FAIRNESS_EN
  logic fetch_lost, fetch_won, force_fetch;

  mem_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clock       (clock),
    .reset       (reset),
    .fetch_lost  (fetch_lost),
    .fetch_won   (fetch_won),
    .force_fetch (force_fetch)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (STARVE_LIMIT != 0);
`endif

  // A response in WAIT is accepted only for the current transaction;
  // rvalid seen in IDLE or ISSUE belongs to nothing and is ignored.
  assign resp = mem_rvalid && (state_q == ST_WAIT);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    drop_d  = drop_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    f_cand  = if_req;
    d_cand  = dm_req;
    arb_go  = 1'b0;
    pick_f  = 1'b0;
`ifdef ARB_FAIRNESS_EN
    fetch_lost = 1'b0;
    fetch_won  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        arb_go = f_cand | d_cand;
      end
      ST_ISSUE: begin
        if (flush && (owner_q == OWN_F)) drop_d = 1'b1;
        if (mem_gnt) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (flush && (owner_q == OWN_F)) drop_d = 1'b1;
        if (mem_rvalid) begin
          drop_d  = 1'b0;
          state_d = ST_IDLE;
          // The owner's request is still high in its completion cycle;
          // only the other requester counts as pending here.
          if (owner_q == OWN_D) d_cand = 1'b0;
          else                  f_cand = 1'b0;
          arb_go = f_cand | d_cand;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (arb_go) begin
`ifdef ARB_FAIRNESS_EN
      pick_f     = f_cand & (~d_cand | force_fetch);
      fetch_won  = pick_f;
      fetch_lost = f_cand & ~pick_f;
`else
      // arb_go guarantees fetch is requesting whenever data is not.
      pick_f = ~d_cand;
`endif
      state_d = ST_ISSUE;
      if (pick_f) begin
        owner_d = OWN_F;
        we_d    = 1'b0;
        addr_d  = if_addr;
        wdata_d = '0;
        size_d  = SZ_W;
      end else begin
        owner_d = OWN_D;
        we_d    = dm_we;
        addr_d  = dm_addr;
        wdata_d = dm_wdata;
        size_d  = dm_size;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_F;
      drop_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      drop_q  <= drop_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
    end
  end

  assign mem_req   = (state_q == ST_ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_size  = size_q;

  // A flush in the response cycle itself also kills the fetch response.
  assign if_valid = resp && (owner_q == OWN_F) && !drop_q && !flush;
  assign dm_valid = resp && (owner_q == OWN_D);

  // Read data is gated so the rdata outputs read 0 whenever no pulse is out.
  assign if_rdata = if_valid ? mem_rdata : '0;
  assign dm_rdata = dm_valid ? mem_rdata : '0;

  assign f_stall   = if_req & ~if_valid;
  assign m_stall   = dm_req & ~dm_valid;
  assign dbg_state = state_q;

endmodule
